// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: message schedule and sequencer feeding a 4-lane interleaved
// SHA-256 round engine. A 64-word shadow buffer collects the next chunk for all
// lanes, and a working window holds the chunk of the pass in flight. W[16..63]
// is expanded on the fly from a 64-deep history of emitted words. The block
// emits one w/k pair per cycle, interleaving the four lanes.
module sha256_msg_sched #(
  parameter int LANES  = 4,
  parameter int ROUNDS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic        in_first_i,
  input  logic        in_last_i,
  output logic [31:0] w_o,
  output logic [31:0] k_o,
  output logic        clr_no,
  output logic        update_o,
  output logic        digest_valid_o,
  output logic [1:0]  digest_lane_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int         WORDS    = LANES * 16;
  localparam logic [7:0] LAST_CYC = 8'(LANES * ROUNDS - 1);
  localparam logic [6:0] FULL_CNT = 7'(WORDS);
  localparam logic [6:0] NEAR_CNT = 7'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Shadow buffer, working window and emitted-word history.
  logic [31:0] shadow [WORDS];
  logic [31:0] window [WORDS];
  logic [31:0] hist_q [63];   // hist_q[i] = word emitted i+2 cycles before the next one
  logic [6:0]  count;
  logic        sh_first, sh_last;

  state_t      state;
  logic [7:0]  cyc;
  logic        cur_first, cur_last;
  logic [1:0]  flush_cnt;
  logic        flush_digest;

  logic        accept, sh_full, full_eff, last_cyc;
  logic        chain, start_idle, discard, release_sh, run_next;
  logic [7:0]  cyc_next;
  logic [31:0] w_next;

  assign in_ready_o = (count != FULL_CNT);
  assign accept     = in_valid_i & in_ready_o;
  assign sh_full    = (count == FULL_CNT);
  // A chunk whose last word lands on the pass's final cycle still chains.
  assign full_eff   = sh_full | ((count == NEAR_CNT) & accept);
  assign last_cyc   = (state == RUN) && (cyc == LAST_CYC);
  assign chain      = last_cyc & full_eff & ~sh_first & ~cur_last;
  assign start_idle = (state == IDLE) & sh_full & sh_first;
  assign discard    = (state == IDLE) & sh_full & ~sh_first;
  assign release_sh = start_idle | chain;
  assign run_next   = release_sh | ((state == RUN) & ~last_cyc);
  assign cyc_next   = release_sh ? 8'd0 : cyc + 8'd1;
  assign busy_o     = (state != IDLE);

  // Next schedule word: raw chunk words for rounds 0..15, expansion afterwards.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = '0;
    if (run_next) begin
      if (cyc_next[7:6] == 2'b00)
        w_next = release_sh ? shadow[0] : window[cyc_next[5:0]];
      else
        w_next = sig1(hist_q[6]) + hist_q[26] + sig0(hist_q[58]) + hist_q[62];
    end
  end

  // Shadow data storage; written on every accepted word.
  // NOTE: pure data arrays carry no reset; the count and flags qualify their contents.
  always_ff @(posedge clk_i) begin
    if (accept) shadow[count[5:0]] <= in_data_i;
  end

  // Shadow occupancy and chunk flags, cleared when the shadow is released or discarded.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments for all registered state.
    if (rst_i) begin
      count    <= '0;
      sh_first <= 1'b0;
      sh_last  <= 1'b0;
    end else if (release_sh || discard) begin
      count <= '0;
    end else if (accept) begin
      count <= count + 7'd1;
      if (count == 7'd0) begin
        sh_first <= in_first_i;
        sh_last  <= in_last_i;
      end
    end
  end

  // Copy the shadow into the working window at pass start, merging a word arriving that cycle.
  always_ff @(posedge clk_i) begin
    if (release_sh) begin
      for (int i = 0; i < WORDS; i++)
        window[i] <= (accept && (count[5:0] == 6'(i))) ? in_data_i : shadow[i];
    end
  end

  // History shift register of emitted schedule words.
  always_ff @(posedge clk_i) begin
    hist_q[0] <= w_o;
    for (int i = 1; i < 63; i++) hist_q[i] <= hist_q[i-1];
  end

  // Sequencer FSM with registered engine controls and schedule outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cyc            <= '0;
      cur_first      <= 1'b0;
      cur_last       <= 1'b0;
      flush_cnt      <= '0;
      flush_digest   <= 1'b0;
      w_o            <= '0;
      k_o            <= '0;
      clr_no         <= 1'b1;
      update_o       <= 1'b0;
      digest_valid_o <= 1'b0;
      digest_lane_o  <= '0;
      err_o          <= 1'b0;
    end else begin
      w_o <= w_next;
      k_o <= run_next ? K256[cyc_next[7:2]] : 32'd0;
      unique case (state)
        IDLE: begin
          update_o       <= 1'b0;
          digest_valid_o <= 1'b0;
          clr_no         <= ~start_idle;
          if (start_idle) begin
            state     <= RUN;
            cyc       <= '0;
            cur_first <= 1'b1;
            cur_last  <= sh_last;
          end else if (discard) begin
            err_o <= 1'b1;
          end
        end
        RUN: begin
          if (chain) begin
            cyc       <= '0;
            cur_first <= 1'b0;
            cur_last  <= sh_last;
            update_o  <= 1'b1;
            clr_no    <= 1'b1;
          end else if (last_cyc) begin
            state        <= FLUSH;
            flush_cnt    <= '0;
            flush_digest <= cur_last;
            update_o     <= 1'b1;
            clr_no       <= 1'b1;
            if (!full_eff && !cur_last) err_o <= 1'b1;
          end else begin
            cyc      <= cyc_next;
            update_o <= ~cur_first & (cyc_next[7:2] == 6'd0);
            clr_no   <= ~(cur_first & (cyc_next[7:2] == 6'd0));
          end
        end
        FLUSH: begin
          flush_cnt      <= flush_cnt + 2'd1;
          digest_valid_o <= flush_digest;
          digest_lane_o  <= flush_digest ? flush_cnt : 2'd0;
          if (flush_cnt == 2'd3) begin
            state    <= DONE;
            update_o <= 1'b0;
          end
        end
        DONE: begin
          state          <= IDLE;
          update_o       <= 1'b0;
          digest_valid_o <= 1'b0;
          digest_lane_o  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: reference schedule expansion per lane,
// single and chained passes, withheld continuation, orphan chunk, mid-pass reset.
module tb_sha256_msg_sched;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_data_i = '0;
  logic        in_first_i = 1'b0;
  logic        in_last_i = 1'b0;
  logic [31:0] w_o, k_o;
  logic        clr_no, update_o, digest_valid_o, busy_o, err_o;
  logic [1:0]  digest_lane_o;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] abc [64];
  logic [31:0] ca [64];
  logic [31:0] cb [64];
  logic [31:0] cc [64];
  logic [31:0] cd [64];
  logic [31:0] seen_w [256];
  logic [31:0] seen_k [256];

  sha256_msg_sched dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .in_first_i     (in_first_i),
    .in_last_i      (in_last_i),
    .w_o            (w_o),
    .k_o            (k_o),
    .clr_no         (clr_no),
    .update_o       (update_o),
    .digest_valid_o (digest_valid_o),
    .digest_lane_o  (digest_lane_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Drive one 64-word load; flags are presented only with idx 0.
  task automatic load_chunk(input string name, input logic [31:0] ch [64],
                            input bit first, input bit last, input bit gaps);
    int idx = 0;
    int guard = 0;
    bit acc;
    @(posedge clk_i); #1;
    while (idx < 64 && guard < 1000) begin
      in_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data_i  = ch[idx];
      in_first_i = first && (idx == 0);
      in_last_i  = last && (idx == 0);
      acc = in_valid_i && in_ready_o;
      @(posedge clk_i); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid_i = 1'b0;
    in_first_i = 1'b0;
    in_last_i  = 1'b0;
    n_vec++;
    if (idx != 64) begin
      n_bad++;
      $display("FAIL %s load: accepted %0d words, want 64", name, idx);
    end
  endtask

  task automatic wait_start(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk_i);
      if (busy_o === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s start: busy_o never rose", name);
    end
  endtask

  // Checks one pass starting at the current negedge (cyc 0); optionally the flush after it.
  task automatic observe_pass(input string name, input logic [31:0] ch [64],
                              input bit first, input bit last, input bit follow);
    logic [31:0] wl [64];
    logic [31:0] em [256];
    logic exp_clr, exp_upd, exp_dv;
    for (int l = 0; l < 4; l++) begin
      for (int j = 0; j < 16; j++) wl[j] = ch[4*j + l];
      for (int j = 16; j < 64; j++)
        wl[j] = ss1(wl[j-2]) + wl[j-7] + ss0(wl[j-15]) + wl[j-16];
      for (int j = 0; j < 64; j++) em[4*j + l] = wl[j];
    end
    for (int c = 0; c < 256; c++) begin
      if (c != 0) @(negedge clk_i);
      seen_w[c] = w_o;
      seen_k[c] = k_o;
      exp_clr = !(first && c < 4);
      exp_upd = !first && c < 4;
      n_vec++;
      if (w_o !== em[c]) begin
        n_bad++;
        $display("FAIL %s w_o cyc=%0d: got %h want %h", name, c, w_o, em[c]);
      end
      n_vec++;
      if (clr_no !== exp_clr || update_o !== exp_upd) begin
        n_bad++;
        $display("FAIL %s ctrl cyc=%0d: clr_no/update_o got %b%b want %b%b",
                 name, c, clr_no, update_o, exp_clr, exp_upd);
      end
      n_vec++;
      if (busy_o !== 1'b1 || digest_valid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL %s run status cyc=%0d: busy/dv got %b%b want 10",
                 name, c, busy_o, digest_valid_o);
      end
    end
    if (follow) begin
      @(negedge clk_i);
    end else begin
      for (int f = 0; f < 4; f++) begin
        @(negedge clk_i);
        n_vec++;
        if (update_o !== 1'b1 || clr_no !== 1'b1 || w_o !== 32'd0 || k_o !== 32'd0) begin
          n_bad++;
          $display("FAIL %s flush%0d: upd/clr/w/k got %b %b %h %h want 1 1 0 0",
                   name, f, update_o, clr_no, w_o, k_o);
        end
        exp_dv = last && (f >= 1);
        n_vec++;
        if (digest_valid_o !== exp_dv || (exp_dv && digest_lane_o !== 2'(f - 1))) begin
          n_bad++;
          $display("FAIL %s flush%0d digest: got dv=%b lane=%0d want dv=%b lane=%0d",
                   name, f, digest_valid_o, digest_lane_o, exp_dv, f - 1);
        end
      end
      @(negedge clk_i);
      n_vec++;
      if (update_o !== 1'b0 || busy_o !== 1'b1 || digest_valid_o !== last ||
          (last && digest_lane_o !== 2'd3)) begin
        n_bad++;
        $display("FAIL %s done: upd/busy/dv/lane got %b %b %b %0d want 0 1 %b 3",
                 name, update_o, busy_o, digest_valid_o, digest_lane_o, last);
      end
      @(negedge clk_i);
      n_vec++;
      if (busy_o !== 1'b0 || digest_valid_o !== 1'b0) begin
        n_bad++;
        $display("FAIL %s idle: busy/dv got %b%b want 00", name, busy_o, digest_valid_o);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_vec++;
    if (in_ready_o !== 1'b1 || w_o !== 32'd0 || k_o !== 32'd0 || clr_no !== 1'b1 ||
        update_o !== 1'b0 || digest_valid_o !== 1'b0 || digest_lane_o !== 2'd0 ||
        busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: rdy=%b w=%h k=%h clr=%b upd=%b dv=%b lane=%0d busy=%b err=%b want 1 0 0 1 0 0 0 0 0",
               name, in_ready_o, w_o, k_o, clr_no, update_o, digest_valid_o,
               digest_lane_o, busy_o, err_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("reset");
  endtask

  task automatic test_abc();
    load_chunk("abc", abc, 1'b1, 1'b1, 1'b0);
    wait_start("abc");
    observe_pass("abc", abc, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (seen_w[64] !== 32'h61626380 || seen_w[68] !== 32'h000f0000) begin
      n_bad++;
      $display("FAIL abc w spot: cyc64=%h cyc68=%h want 61626380 000f0000", seen_w[64], seen_w[68]);
    end
    n_vec++;
    if (seen_k[0] !== 32'h428a2f98 || seen_k[4] !== 32'h71374491 || seen_k[252] !== 32'hc67178f2) begin
      n_bad++;
      $display("FAIL abc k spot: cyc0=%h cyc4=%h cyc252=%h want 428a2f98 71374491 c67178f2",
               seen_k[0], seen_k[4], seen_k[252]);
    end
  endtask

  task automatic test_back_to_back();
    load_chunk("b2b a", ca, 1'b1, 1'b0, 1'b0);
    wait_start("b2b");
    fork
      observe_pass("b2b p1", ca, 1'b1, 1'b0, 1'b1);
      load_chunk("b2b b", cb, 1'b0, 1'b1, 1'b0);
    join
    observe_pass("b2b p2", cb, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b err_o: got %b want 0", err_o);
    end
  endtask

  task automatic test_random_valid();
    load_chunk("rnd c", cc, 1'b1, 1'b0, 1'b1);
    wait_start("rnd");
    fork
      observe_pass("rnd p1", cc, 1'b1, 1'b0, 1'b1);
      begin
        load_chunk("rnd d", cd, 1'b0, 1'b1, 1'b1);
        in_valid_i = 1'b1;
        in_data_i  = 32'hbad0bad0;
        @(negedge clk_i);
        n_vec++;
        if (in_ready_o !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd ready after 64 words: got %b want 0", in_ready_o);
        end
        repeat (3) @(negedge clk_i);
        in_valid_i = 1'b0;
      end
    join
    observe_pass("rnd p2", cd, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rnd err_o: got %b want 0", err_o);
    end
  endtask

  task automatic test_err_withheld();
    load_chunk("err a", ca, 1'b1, 1'b0, 1'b0);
    wait_start("err");
    observe_pass("err p1", ca, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL err set: got %b want 1", err_o);
    end
    load_chunk("err abc", abc, 1'b1, 1'b1, 1'b0);
    wait_start("err abc");
    observe_pass("err abc", abc, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL err sticky: got %b want 1", err_o);
    end
  endtask

  task automatic test_reset_midpass();
    load_chunk("rst abc", abc, 1'b1, 1'b1, 1'b0);
    wait_start("rst");
    repeat (90) @(negedge clk_i);
    for (int i = 0; i < 10; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 32'hdead0000 + 32'(i);
      in_first_i = (i == 0);
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    in_first_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("reset mid-pass");
    load_chunk("rst reload", abc, 1'b1, 1'b1, 1'b0);
    wait_start("rst reload");
    observe_pass("rst reload", abc, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_orphan();
    load_chunk("orphan", cb, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_vec++;
      if (busy_o !== 1'b0) begin
        n_bad++;
        $display("FAIL orphan busy %0d: got %b want 0", i, busy_o);
      end
    end
    n_vec++;
    if (err_o !== 1'b1 || in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL orphan discard: err/ready got %b%b want 11", err_o, in_ready_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      abc[i] = 32'd0;
      ca[i]  = 32'(i + 1) * 32'h9e3779b9;
      cb[i]  = 32'(i * i + 7) * 32'h85ebca6b;
      cc[i]  = $urandom;
      cd[i]  = $urandom;
    end
    abc[0]  = 32'h61626380;
    abc[60] = 32'h00000018;

    test_reset();
    test_abc();
    test_back_to_back();
    test_random_valid();
    test_err_withheld();
    test_reset_midpass();
    test_orphan();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
